// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution feeder path.
//  - state_e  : sequencer states
//  - CTRL_*   : kernel3x3 ctrl[3:0] codes per phase
//  - tag_t    : per-cycle output tag {valid, msb, last}
//  - weight_nibble(): pick k[r][c] out of the packed 36-bit weight word
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LSB,
    ST_MSB,
    ST_FLUSH
  } state_e;

  localparam logic [3:0] CTRL_IDLE  = 4'b0000;
  localparam logic [3:0] CTRL_WLOAD = 4'b0001;
  localparam logic [3:0] CTRL_LSB   = 4'b0010;
  localparam logic [3:0] CTRL_MSB   = 4'b1100;

  localparam int unsigned WLOAD_CYCLES = 5;

  typedef struct packed {
    logic valid;
    logic msb;
    logic last;
  } tag_t;

  // k[r][c] lives at bits [4*(3r+c) +: 4]
  function automatic logic [3:0] weight_nibble(input logic [35:0] w,
                                               input int unsigned r,
                                               input int unsigned c);
    logic [35:0] shifted;
    shifted = w >> (4 * (3 * r + c));
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/kernel3x3_feeder_tag_delay_line.sv
// tag_delay_line: fixed-depth shift register carrying per-cycle tags so they
// line up with the kernel's serial result bytes.
// Ports:
//  clk        in  clock, rising edge
//  clr_n      in  synchronous clear, active low (empties every stage)
//  push_i     in  tag entering the line this cycle
//  tail_o     out tag leaving the line (pushed DEPTH cycles earlier)
//  occupied_o out some stage holds a tag with bit OCC_BIT set
module tag_delay_line #(
  parameter int WIDTH   = 3,
  parameter int DEPTH   = 8,
  parameter int OCC_BIT = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] push_i,
  output logic [WIDTH-1:0] tail_o,
  output logic             occupied_o
);

  logic [WIDTH-1:0] line_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign tail_o = line_q[DEPTH-1];

  always_comb begin
    occupied_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) occupied_o = occupied_o | line_q[i][OCC_BIT];
  end

endmodule

// File: rtl/kernel3x3_feeder.sv
// kernel3x3_feeder: sequencer in front of kernel3x3. Loads nine shift-code
// weights into the PE array, then streams 3-row pixel columns as LSB/MSB
// cycle pairs, and emits a delayed tag stream aligned with the kernel's
// serial 8-bit result.
// Ports:
//  clk, rst_n               clock / synchronous active-low reset
//  w_valid, w_data, w_ready weight set handshake (accepted only in IDLE)
//  s_valid, s_data, s_last  pixel column stream {row3,row2,row1}
//  s_ready                  high in the LSB slot only
//  k_ctrl, k_in1..k_in3     drive kernel3x3 ctrl and row inputs
//  o_valid, o_msb, o_last   tag for the kernel output byte of this cycle
//  busy                     frame in progress or real tags still in flight
module kernel3x3_feeder
  import conv_pkg::*;
#(
  parameter int OUT_LAT     = 8,
  parameter int FLUSH_PAIRS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_valid,
  input  logic [35:0] w_data,
  output logic        w_ready,
  input  logic        s_valid,
  input  logic [23:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic [3:0]  k_ctrl,
  output logic [7:0]  k_in1,
  output logic [7:0]  k_in2,
  output logic [7:0]  k_in3,
  output logic        o_valid,
  output logic        o_msb,
  output logic        o_last,
  output logic        busy
);

  localparam int FLUSH_CYC = 2 * FLUSH_PAIRS;
  localparam int CNT_MAX   = (FLUSH_CYC > int'(WLOAD_CYCLES)) ? FLUSH_CYC : int'(WLOAD_CYCLES);
  localparam int CNT_W     = $clog2(CNT_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [35:0]      w_q, w_d;
  logic [23:0]      pix_q, pix_d;
  logic             pix_vld_q, pix_vld_d;
  logic             pix_last_q, pix_last_d;
  tag_t             push_tag, out_tag;
  logic             tags_in_flight;
  int unsigned      wcol;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_d        = w_q;
    pix_d      = pix_q;
    pix_vld_d  = pix_vld_q;
    pix_last_d = pix_last_q;
    push_tag   = '0;
    w_ready    = 1'b0;
    s_ready    = 1'b0;
    k_ctrl     = CTRL_IDLE;
    k_in1      = '0;
    k_in2      = '0;
    k_in3      = '0;
    // Column 2 is fed first so it shifts furthest (into PE3), column 0 last.
    wcol       = (cnt_q < 2) ? 2 : (cnt_q < 4) ? 1 : 0;

    case (state_q)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_d     = w_data;
          cnt_d   = '0;
          state_d = ST_LOAD_W;
        end
      end

      ST_LOAD_W: begin
        k_ctrl = CTRL_WLOAD;
        k_in1  = {4'b0, weight_nibble(w_q, 0, wcol)};
        k_in2  = {4'b0, weight_nibble(w_q, 1, wcol)};
        k_in3  = {4'b0, weight_nibble(w_q, 2, wcol)};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WLOAD_CYCLES - 1)) state_d = ST_LSB;
      end

      ST_LSB: begin
        k_ctrl  = CTRL_LSB;
        s_ready = 1'b1;
        // A missing column still consumes a pair: the array never stalls.
        if (s_valid) begin
          {k_in3, k_in2, k_in1} = s_data;
          pix_d      = s_data;
          pix_vld_d  = 1'b1;
          pix_last_d = s_last;
          push_tag   = '{valid: 1'b1, msb: 1'b0, last: 1'b0};
        end else begin
          pix_d      = '0;
          pix_vld_d  = 1'b0;
          pix_last_d = 1'b0;
        end
        state_d = ST_MSB;
      end

      ST_MSB: begin
        k_ctrl = CTRL_MSB;
        {k_in3, k_in2, k_in1} = pix_q;
        push_tag = '{valid: pix_vld_q, msb: 1'b1, last: pix_vld_q & pix_last_q};
        if (pix_vld_q && pix_last_q) begin
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_LSB;
        end
      end

      ST_FLUSH: begin
        // cnt_q[0] gives the LSB/MSB phase of each drain pair.
        k_ctrl   = cnt_q[0] ? CTRL_MSB : CTRL_LSB;
        push_tag = '{valid: 1'b0, msb: cnt_q[0], last: 1'b0};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FLUSH_CYC - 1)) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pix_vld_q  <= 1'b0;
      pix_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pix_vld_q  <= pix_vld_d;
      pix_last_q <= pix_last_d;
    end
  end

  always_ff @(posedge clk) begin
    w_q   <= w_d;
    pix_q <= pix_d;
  end

  // Reset clears the line too, so an aborted frame leaves no stray tags.
  tag_delay_line #(
    .WIDTH  (3),
    .DEPTH  (OUT_LAT),
    .OCC_BIT(2)
  ) u_tags (
    .clk       (clk),
    .clr_n     (rst_n),
    .push_i    (push_tag),
    .tail_o    (out_tag),
    .occupied_o(tags_in_flight)
  );

  assign o_valid = out_tag.valid;
  assign o_msb   = out_tag.msb;
  assign o_last  = out_tag.last;
  assign busy    = (state_q != ST_IDLE) | tags_in_flight;

endmodule

// File: tb/tb_kernel3x3_feeder.sv
module tb_kernel3x3_feeder;
  localparam int OUT_LAT     = 8;
  localparam int FLUSH_PAIRS = 4;
  localparam int MAXC        = 4096;

  localparam logic [3:0] C_IDLE  = 4'b0000;
  localparam logic [3:0] C_WLOAD = 4'b0001;
  localparam logic [3:0] C_LSB   = 4'b0010;
  localparam logic [3:0] C_MSB   = 4'b1100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_valid = 1'b0;
  logic [35:0] w_data = '0;
  logic        w_ready;
  logic        s_valid = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [3:0]  k_ctrl;
  logic [7:0]  k_in1, k_in2, k_in3;
  logic        o_valid, o_msb, o_last, busy;

  always #5 clk = ~clk;

  kernel3x3_feeder #(.OUT_LAT(OUT_LAT), .FLUSH_PAIRS(FLUSH_PAIRS)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .k_ctrl(k_ctrl), .k_in1(k_in1), .k_in2(k_in2), .k_in3(k_in3),
    .o_valid(o_valid), .o_msb(o_msb), .o_last(o_last), .busy(busy)
  );

  // Expected per-cycle schedule, indexed by cycle number.
  logic [3:0]  e_ctrl   [MAXC];
  logic [23:0] e_in     [MAXC];
  logic        e_sready [MAXC];
  logic        e_wready [MAXC];
  logic        e_active [MAXC];
  logic        e_chk    [MAXC];
  logic [2:0]  e_push   [MAXC];   // {valid, msb, last} produced in that cycle
  int          pin_k1   [MAXC];

  int cyc = 0;
  int last_rst = 0;
  int n_cmp = 0;
  int n_err = 0;
  int pin_olast = -1;
  int pin_busy = -1;
  logic busy_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [35:0] w, input int r, input int c);
    logic [35:0] t;
    t = w >> (4 * (3 * r + c));
    return t[3:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget actual=%0d required<%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    rst_n   = 1'b1;
    w_valid = 1'b0;
    w_data  = 36'({$urandom(), $urandom()});
    s_valid = 1'($urandom_range(0, 1));
    s_data  = 24'($urandom());
    s_last  = 1'($urandom_range(0, 1));
    e_chk[cyc]    = 1'b1;
    e_active[cyc] = 1'b1;
    e_ctrl[cyc]   = C_IDLE;
    e_in[cyc]     = '0;
    e_sready[cyc] = 1'b0;
    e_wready[cyc] = 1'b0;
    e_push[cyc]   = '0;
    pin_k1[cyc]   = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      e_active[cyc] = 1'b0;
      e_wready[cyc] = 1'b1;
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      rst_n = 1'b0;
      e_chk[cyc] = 1'b0;
      last_rst = cyc;
    end
  endtask

  // One frame: handshake, 5 weight cycles, LSB/MSB slots until ncols columns
  // are accepted, then the drain pairs. rst_col>=0 aborts with reset in the
  // MSB slot of that (0-based) column.
  task automatic run_frame(input logic [35:0] W, input int ncols, input int bub_pct,
                           input int force_bub_at, input int rst_col, input bit hold,
                           input bit pin_load);
    int lit[5] = '{3, 3, 2, 2, 1};
    int acc = 0;
    int slot = 0;
    int last_lsb = 0;
    step();
    e_active[cyc] = 1'b0;
    e_wready[cyc] = 1'b1;
    w_valid = 1'b1;
    w_data  = W;
    for (int k = 0; k < 5; k++) begin
      int col;
      step();
      w_valid = 1'($urandom_range(0, 1));
      col = (k < 2) ? 2 : (k < 4) ? 1 : 0;
      e_ctrl[cyc] = C_WLOAD;
      e_in[cyc]   = {4'h0, nib(W, 2, col), 4'h0, nib(W, 1, col), 4'h0, nib(W, 0, col)};
      if (pin_load) pin_k1[cyc] = lit[k];
    end
    while (acc < ncols) begin
      bit bub;
      bit vlast;
      logic [23:0] d;
      bub = (force_bub_at >= 0 && slot >= force_bub_at && slot < force_bub_at + 3) ||
            (int'($urandom_range(0, 99)) < bub_pct);
      vlast = !bub && (acc == ncols - 1);
      // LSB slot
      step();
      w_valid = 1'($urandom_range(0, 1));
      s_valid = !bub;
      if (!bub) s_last = vlast;
      d = s_data;
      e_ctrl[cyc]   = C_LSB;
      e_sready[cyc] = 1'b1;
      e_in[cyc]     = bub ? 24'h0 : d;
      e_push[cyc]   = {!bub, 1'b0, 1'b0};
      if (vlast) last_lsb = cyc;
      // MSB slot
      step();
      w_valid = 1'($urandom_range(0, 1));
      if (hold) s_valid = 1'b1;
      e_ctrl[cyc] = C_MSB;
      e_in[cyc]   = bub ? 24'h0 : d;
      e_push[cyc] = {!bub, 1'b1, vlast};
      if (!bub) acc++;
      if (rst_col >= 0 && !bub && acc == rst_col + 1) begin
        rst_n = 1'b0;
        e_chk[cyc] = 1'b0;
        e_push[cyc] = '0;
        last_rst = cyc;
        pin_busy = cyc + 1;
        return;
      end
      slot++;
    end
    pin_olast = last_lsb + OUT_LAT + 1;
    pin_busy  = last_lsb + 1 + OUT_LAT + 1;
    for (int f = 0; f < 2 * FLUSH_PAIRS; f++) begin
      step();
      w_valid = 1'($urandom_range(0, 1));
      e_ctrl[cyc] = (f % 2 == 1) ? C_MSB : C_LSB;
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0 && e_chk[cyc]) begin
      int p;
      logic [2:0] et;
      logic eb;
      check("k_ctrl", 32'(k_ctrl), 32'(e_ctrl[cyc]));
      check("k_in1", 32'(k_in1), 32'(e_in[cyc][7:0]));
      check("k_in2", 32'(k_in2), 32'(e_in[cyc][15:8]));
      check("k_in3", 32'(k_in3), 32'(e_in[cyc][23:16]));
      check("s_ready", 32'(s_ready), 32'(e_sready[cyc]));
      check("w_ready", 32'(w_ready), 32'(e_wready[cyc]));
      p  = cyc - OUT_LAT;
      et = (p > last_rst) ? e_push[p] : 3'b000;
      check("o_valid", 32'(o_valid), 32'(et[2]));
      check("o_last", 32'(o_last), 32'(et[0]));
      if (et[2]) check("o_msb", 32'(o_msb), 32'(et[1]));
      eb = e_active[cyc];
      for (int q = cyc - OUT_LAT; q < cyc; q++)
        if (q > last_rst && e_push[q][2]) eb = 1'b1;
      check("busy", 32'(busy), 32'(eb));
      if (pin_k1[cyc] >= 0) check("k_in1_literal", 32'(k_in1), 32'(pin_k1[cyc]));
      if (o_last && pin_olast >= 0) check("o_last_time", 32'(cyc), 32'(pin_olast));
      if (busy_prev && !busy && pin_busy >= 0) check("busy_fall_time", 32'(cyc), 32'(pin_busy));
    end
    busy_prev = busy;
  end

  initial begin
    reset_cycles(3);
    idle(3);
    // Weights k[r][c] = 1 + c in every row; pixels stream with s_valid held.
    run_frame(36'h321321321, 6, 0, -1, -1, 1'b1, 1'b1);
    idle(OUT_LAT + 4);
    // Three forced bubble slots mid-frame, w_valid noise throughout.
    run_frame(36'({$urandom(), $urandom()}), 10, 0, 4, -1, 1'b0, 1'b0);
    idle(OUT_LAT + 4);
    // Reset during the MSB slot of column 3.
    run_frame(36'({$urandom(), $urandom()}), 5, 0, -1, 2, 1'b0, 1'b0);
    idle(OUT_LAT + 4);
    for (int i = 0; i < 12; i++) begin
      run_frame(36'({$urandom(), $urandom()}), int'($urandom_range(1, 12)), 30, -1, -1, 1'b0, 1'b0);
      idle(int'($urandom_range(OUT_LAT + 2, OUT_LAT + 6)));
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
